// File: rtl/cm0_ctrl_pkg.sv
// Shared state encoding, latched decoder-class record and default sizes
// for the cm0 control sequencer.
package cm0_ctrl_pkg;

  localparam int CNT_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_EXC     = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

  typedef struct packed {
    logic load;
    logic store;
    logic wr_rd;
    logic wr_sp;
    logic wr_lr;
    logic set_flags;
    logic wr_primask;
  } cls_t;

endpackage

// File: rtl/cm0_ctrl_watchdog.sv
// Wait-cycle counter: cleared by load, advanced by en; expired flags the
// last permitted wait cycle (combinational, same cycle as the count match).
module cm0_ctrl_watchdog
  import cm0_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !load && (cnt_q == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cm0_ctrl_seq.sv
// Multi-cycle instruction sequencer; ALU op 4 cycles FETCH..WB, load/store 5, +1 per
// memory wait cycle. Optional ack watchdog under CM0_CTRL_WATCHDOG_EN.
module cm0_ctrl_seq
  import cm0_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef CM0_CTRL_WATCHDOG_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             irq_pend,
  input  logic             primask_q,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_wr_rd,
  input  logic             dec_wr_sp,
  input  logic             dec_wr_lr,
  input  logic             dec_set_flags,
  input  logic             dec_wr_primask,
  output logic             cu_decode,
  output logic             cu_execute,
  output logic             cu_wr_mem,
  output logic             ld_sp,
  output logic             ld_lr,
  output logic             ld_pc,
  output logic             ld_rd,
  output logic             ld_apsr,
  output logic             ld_ipsr,
  output logic             ld_primask,
  output logic             busy,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wd_expired;

`ifdef CM0_CTRL_WATCHDOG_EN
  logic wd_wait, wd_ack;
  logic err_q, err_d;

  assign wd_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wd_ack  = (state_q == ST_FETCH) ? fetch_ack : mem_ack;

  // Counter is held clear outside the wait states, so each entry restarts it.
  cm0_ctrl_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .load    (!wd_wait),
    .en      (wd_wait && !wd_ack),
    .expired (wd_expired)
  );

  always_comb begin
    err_d = err_q | wd_expired;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign wd_expired  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    retired_d  = retired_q;
    fetch_req  = 1'b0;
    mem_req    = 1'b0;
    cu_decode  = 1'b0;
    cu_execute = 1'b0;
    cu_wr_mem  = 1'b0;
    ld_sp      = 1'b0;
    ld_lr      = 1'b0;
    ld_pc      = 1'b0;
    ld_rd      = 1'b0;
    ld_apsr    = 1'b0;
    ld_ipsr    = 1'b0;
    ld_primask = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack)       state_d = ST_DECODE;
        else if (wd_expired) state_d = ST_HALT;
      end
      ST_DECODE: begin
        cu_decode = 1'b1;
        // Load together with store is illegal; it degrades to a store.
        cls_d.load       = dec_load & ~dec_store;
        cls_d.store      = dec_store;
        cls_d.wr_rd      = dec_wr_rd;
        cls_d.wr_sp      = dec_wr_sp;
        cls_d.wr_lr      = dec_wr_lr;
        cls_d.set_flags  = dec_set_flags;
        cls_d.wr_primask = dec_wr_primask;
        state_d          = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        cu_execute = 1'b1;
        ld_apsr    = cls_q.set_flags;
        state_d    = (cls_q.load || cls_q.store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        cu_wr_mem = cls_q.store;
        if (mem_ack)         state_d = ST_WB;
        else if (wd_expired) state_d = ST_HALT;
      end
      ST_WB: begin
        ld_pc      = 1'b1;
        ld_rd      = cls_q.wr_rd;
        ld_sp      = cls_q.wr_sp;
        ld_lr      = cls_q.wr_lr;
        ld_primask = cls_q.wr_primask;
        retired_d  = retired_q + CNT_W'(1);
        if (halt_req)                   state_d = ST_HALT;
        else if (irq_pend && !primask_q) state_d = ST_EXC;
        else                            state_d = ST_FETCH;
      end
      ST_EXC: begin
        ld_ipsr = 1'b1;
        ld_lr   = 1'b1;
        ld_pc   = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cls_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted  = (state_q == ST_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_cm0_ctrl_seq.sv
// Bench for cm0_ctrl_seq: per-cycle expected strobe traces built from the
// instruction-level timing rules, table vectors plus randomized instructions.
module tb_cm0_ctrl_seq;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, start, halt_req, irq_pend, primask_q, fetch_ack, mem_ack;
  logic dec_load, dec_store, dec_wr_rd, dec_wr_sp, dec_wr_lr, dec_set_flags, dec_wr_primask;
  logic fetch_req, mem_req, cu_decode, cu_execute, cu_wr_mem;
  logic ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask;
  logic busy, halted, err_timeout;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  cm0_ctrl_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .irq_pend(irq_pend),
    .primask_q(primask_q), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .mem_req(mem_req), .mem_ack(mem_ack), .dec_load(dec_load), .dec_store(dec_store),
    .dec_wr_rd(dec_wr_rd), .dec_wr_sp(dec_wr_sp), .dec_wr_lr(dec_wr_lr),
    .dec_set_flags(dec_set_flags), .dec_wr_primask(dec_wr_primask),
    .cu_decode(cu_decode), .cu_execute(cu_execute), .cu_wr_mem(cu_wr_mem),
    .ld_sp(ld_sp), .ld_lr(ld_lr), .ld_pc(ld_pc), .ld_rd(ld_rd), .ld_apsr(ld_apsr),
    .ld_ipsr(ld_ipsr), .ld_primask(ld_primask), .busy(busy), .halted(halted),
    .err_timeout(err_timeout), .retired(retired)
  );

  logic [14:0] outs;
  assign outs = {err_timeout, fetch_req, mem_req, cu_decode, cu_execute, cu_wr_mem,
                 ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask, busy, halted};

  localparam logic [14:0] M_ERR  = 15'd1 << 14;
  localparam logic [14:0] M_FREQ = 15'd1 << 13;
  localparam logic [14:0] M_MREQ = 15'd1 << 12;
  localparam logic [14:0] M_DEC  = 15'd1 << 11;
  localparam logic [14:0] M_EXE  = 15'd1 << 10;
  localparam logic [14:0] M_WRM  = 15'd1 << 9;
  localparam logic [14:0] M_SP   = 15'd1 << 8;
  localparam logic [14:0] M_LR   = 15'd1 << 7;
  localparam logic [14:0] M_PC   = 15'd1 << 6;
  localparam logic [14:0] M_RD   = 15'd1 << 5;
  localparam logic [14:0] M_APSR = 15'd1 << 4;
  localparam logic [14:0] M_IPSR = 15'd1 << 3;
  localparam logic [14:0] M_PRIM = 15'd1 << 2;
  localparam logic [14:0] M_BUSY = 15'd1 << 1;
  localparam logic [14:0] M_HALT = 15'd1;

  // flags: [6] load [5] store [4] wr_rd [3] wr_sp [2] wr_lr [1] set_flags [0] wr_primask
  typedef struct {
    logic [6:0] flags;
    int         fd;   // fetch wait cycles before ack
    int         md;   // memory wait cycles before ack
    bit         hq;
    bit         irq;
    bit         pm;
  } instr_t;

  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] model_ret = '0;
  logic             model_err = 1'b0;

  function automatic logic pick(input int v);
    if (v < 0) return $urandom_range(0, 1) != 0;
    return v != 0;
  endfunction

  function automatic logic [14:0] errm();
    return model_err ? M_ERR : 15'd0;
  endfunction

  task automatic check(input string nm, input logic [14:0] got_o, input logic [CNT_W-1:0] got_r,
                       input logic [14:0] exp_o, input logic [CNT_W-1:0] exp_r);
    tests++;
    if (got_o !== exp_o || got_r !== exp_r) begin
      fails++;
      $display("FAIL %s: got out=%b retired=%0d, expected out=%b retired=%0d",
               nm, got_o, got_r, exp_o, exp_r);
    end
  endtask

  // One clock: compare state-driven outputs at negedge, then drive this cycle's inputs.
  // Input argument -1 means "don't care": a random value the DUT must ignore.
  task automatic cyc(input string nm, input logic [14:0] exp, input int fack, input int mack,
                     input int st, input int hq, input int ip, input int pm,
                     input bit dvld, input logic [6:0] df);
    @(negedge clk);
    check(nm, outs, retired, exp | errm(), model_ret);
    fetch_ack = pick(fack);
    mem_ack   = pick(mack);
    start     = pick(st);
    halt_req  = pick(hq);
    irq_pend  = pick(ip);
    primask_q = pick(pm);
    {dec_load, dec_store, dec_wr_rd, dec_wr_sp, dec_wr_lr, dec_set_flags, dec_wr_primask} =
        dvld ? df : 7'($urandom);
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH again (or in HALT after start).
  task automatic run_instr(input instr_t t);
    logic [14:0] wb;
    bit ls;
    ls = t.flags[6] | t.flags[5];
    for (int i = 0; i <= t.fd; i++)
      cyc("fetch", M_FREQ | M_BUSY, (i == t.fd) ? 1 : 0, -1, -1, -1, -1, -1, 0, '0);
    cyc("decode", M_DEC | M_BUSY, -1, -1, -1, -1, -1, -1, 1, t.flags);
    cyc("execute", M_EXE | M_BUSY | (t.flags[1] ? M_APSR : 15'd0), -1, -1, -1, -1, -1, -1, 0, '0);
    if (ls) begin
      for (int i = 0; i <= t.md; i++)
        cyc("mem", M_MREQ | M_BUSY | (t.flags[5] ? M_WRM : 15'd0),
            -1, (i == t.md) ? 1 : 0, -1, -1, -1, -1, 0, '0);
    end
    wb = M_PC | M_BUSY | (t.flags[4] ? M_RD : 15'd0) | (t.flags[3] ? M_SP : 15'd0) |
         (t.flags[2] ? M_LR : 15'd0) | (t.flags[0] ? M_PRIM : 15'd0);
    cyc("wb", wb, -1, -1, -1, int'(t.hq), int'(t.irq), int'(t.pm), 0, '0);
    model_ret = model_ret + 1'b1;
    if (t.hq) begin
      cyc("halt_hold", M_HALT, -1, -1, 0, -1, -1, -1, 0, '0);
      cyc("halt_start", M_HALT, -1, -1, 1, -1, -1, -1, 0, '0);
    end else if (t.irq && !t.pm) begin
      cyc("exc", M_IPSR | M_LR | M_PC | M_BUSY, -1, -1, -1, -1, -1, -1, 0, '0);
    end
  endtask

  instr_t tbl[9];
  instr_t alu;
  instr_t r;

  initial begin
    tbl[0] = '{7'b0010010, 0, 0, 0, 0, 0};  // ALU: rd + flags, immediate ack
    tbl[1] = '{7'b0100000, 0, 3, 0, 0, 0};  // store, mem_ack after 3 waits
    tbl[2] = '{7'b1010000, 1, 0, 0, 0, 0};  // load into rd
    tbl[3] = '{7'b1100010, 0, 1, 0, 0, 0};  // load+store -> store
    tbl[4] = '{7'b0010000, 0, 0, 0, 1, 0};  // irq taken
    tbl[5] = '{7'b0010000, 0, 0, 0, 1, 1};  // irq masked
    tbl[6] = '{7'b0000010, 0, 0, 1, 1, 0};  // halt beats irq
    tbl[7] = '{7'b0010000, 0, 0, 0, 1, 0};  // irq still pending after restart
    tbl[8] = '{7'b0001101, 2, 0, 0, 0, 0};  // sp/lr/primask writers
    alu    = '{7'b0010010, 0, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; halt_req = 1'b0; irq_pend = 1'b0; primask_q = 1'b0;
    fetch_ack = 1'b0; mem_ack = 1'b0;
    {dec_load, dec_store, dec_wr_rd, dec_wr_sp, dec_wr_lr, dec_set_flags, dec_wr_primask} = '0;

    #12;
    check("reset", outs, retired, 15'd0, '0);
    @(negedge clk);
    rst = 1'b0;

    cyc("idle", 15'd0, -1, -1, 0, -1, -1, -1, 0, '0);
    cyc("idle", 15'd0, -1, -1, 0, -1, -1, -1, 0, '0);
    cyc("idle_start", 15'd0, -1, -1, 1, -1, -1, -1, 0, '0);

    for (int i = 0; i < 9; i++) run_instr(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      r.flags = 7'($urandom);
      r.fd    = $urandom_range(0, 3);
      r.md    = $urandom_range(0, 3);
      r.hq    = ($urandom_range(0, 5) == 0);
      r.irq   = ($urandom_range(0, 2) == 0);
      r.pm    = $urandom_range(0, 1) != 0;
      run_instr(r);
    end

    // Reset while waiting on a store: outputs must drop without a clock edge.
    cyc("pre_rst_fetch", M_FREQ | M_BUSY, 1, -1, -1, -1, -1, -1, 0, '0);
    cyc("pre_rst_decode", M_DEC | M_BUSY, -1, -1, -1, -1, -1, -1, 1, 7'b0100000);
    cyc("pre_rst_exec", M_EXE | M_BUSY, -1, -1, -1, -1, -1, -1, 0, '0);
    cyc("pre_rst_mem", M_MREQ | M_WRM | M_BUSY, -1, 0, 0, -1, -1, -1, 0, '0);
    rst = 1'b1;
    #1;
    check("rst_mid_mem", outs, retired, 15'd0, '0);
    model_ret = '0;
    model_err = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    cyc("post_rst_idle", 15'd0, -1, -1, 1, -1, -1, -1, 0, '0);

    for (int i = 0; i < 16; i++) run_instr(alu);
    @(posedge clk);
    #1;
    check("wrap", outs, retired, M_FREQ | M_BUSY | errm(), 4'd0);

`ifdef CM0_CTRL_WATCHDOG_EN
    for (int i = 0; i < 16; i++)
      cyc("wd_fetch", M_FREQ | M_BUSY, 0, -1, -1, -1, -1, -1, 0, '0);
    model_err = 1'b1;
    cyc("wd_halt", M_HALT, -1, -1, 0, -1, -1, -1, 0, '0);
    cyc("wd_halt_start", M_HALT, -1, -1, 1, -1, -1, -1, 0, '0);
    run_instr(alu);
    rst = 1'b1;
    #1;
    check("wd_rst_clear", outs, retired, 15'd0, '0);
    model_ret = '0;
    model_err = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    cyc("wd_post_rst", 15'd0, -1, -1, 0, -1, -1, -1, 0, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no completion, expected finish within budget");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/cm0_ctrl_seq.md
# cm0_ctrl_seq

Multi-cycle instruction sequencer for the Cortex-M0 core, replacing the fixed test-count control unit. A state machine walks each instruction through fetch, decode, execute, optional data-memory access and write-back. It handshakes with the fetch and data memory ports and issues one-cycle load strobes to the core registers (SP, LR, PC, Rd), APSR, IPSR and PRIMASK. It also counts retired instructions and takes pending interrupts between instructions.

## Interface
- CNT_W, 32: width of retired-instruction counter
- TIMEOUT_CYC, 16: max wait cycles for a memory ack (watchdog build only)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  leave IDLE/HALT and begin fetching
- halt_req  in  1  stop after current instruction
- irq_pend  in  1  level interrupt request
- primask_q  in  1  current PRIMASK; 1 masks irq_pend
- fetch_req / fetch_ack  out / in  1  instruction fetch handshake
- mem_req / mem_ack  out / in  1  data memory handshake
- dec_load, dec_store, dec_wr_rd, dec_wr_sp, dec_wr_lr, dec_set_flags, dec_wr_primask  in  1 each  decoder class flags, valid in DECODE
- cu_decode, cu_execute, cu_wr_mem  out  1  phase strobes; cu_wr_mem = store write enable
- ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ld_primask  out  1  register load strobes
- busy  out  1  state not IDLE/HALT
- halted  out  1  state == HALT
- err_timeout  out  1  sticky watchdog error
- retired  out  CNT_W  instructions completed

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, EXC, HALT. Moore outputs decoded from state plus latched class flags.
- IDLE: all strobes 0. start=1 → FETCH. Otherwise stay.
- FETCH: fetch_req=1 until fetch_ack. An ack in the same cycle as the request counts. On ack → DECODE.
- DECODE: cu_decode=1. Latch all dec_* flags. Asserting both dec_load and dec_store is illegal and is treated as a store. → EXECUTE.
- EXECUTE: cu_execute=1; ld_apsr=dec_set_flags.
  - Load or store → MEM; else → WB.
- MEM: mem_req=1, cu_wr_mem=latched store, held until mem_ack. → WB.
- WB: ld_pc=1. ld_rd, ld_sp, ld_lr, ld_primask follow the latched flags. retired increments and wraps modulo 2^CNT_W.
- Next state after WB:
  - halt_req → HALT.
  - Else irq_pend & ~primask_q → EXC.
  - Else → FETCH.
- EXC: one cycle with ld_ipsr=ld_lr=ld_pc=1. → FETCH.
- HALT: start → FETCH.
- Priority rules:
  - halt_req beats irq at WB; irq stays pending.
  - start is ignored outside IDLE/HALT.
  - Acks arriving while not requesting are ignored.

## Timing
- Reset (async): state=IDLE; every output 0; retired=0; err_timeout=0. Reset mid-instruction abandons it without any strobe.
- Minimum latency, ack in first request cycle:
  - ALU instruction: FETCH→WB = 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- Every ld_* and cu_* strobe is exactly one cycle wide, except cu_wr_mem, which is held through MEM.
- retired updates on the clock edge leaving WB.

## Configuration
- CM0_CTRL_WATCHDOG_EN defined:
  - A wait counter runs in FETCH and MEM and clears on each entry.
  - On TIMEOUT_CYC cycles without an ack: state → HALT and err_timeout=1, sticky until rst.
  - Leaving HALT via start does not clear err_timeout.
- Undefined: waits indefinitely; err_timeout tied 0.

## Structure
- Package cm0_ctrl_pkg holds the state enum (3-bit encoding) and the default CNT_W / TIMEOUT_CYC constants.
- One sub-module, cm0_ctrl_watchdog: a load/count/expire counter, instantiated only under CM0_CTRL_WATCHDOG_EN.

## Test plan
- rst pulse, then start, with an ALU instruction (dec_wr_rd=1, dec_set_flags=1) and acks immediate:
  - cu_decode at cycle 2, cu_execute+ld_apsr at 3, ld_pc+ld_rd at 4.
  - retired=1.
- Store with mem_ack delayed 3 cycles → cu_wr_mem and mem_req high for 4 cycles, then WB; latency 8.
- irq_pend=1, primask_q=0 at WB → EXC cycle with ld_ipsr/ld_lr/ld_pc=1, then FETCH. With primask_q=1 → no EXC.
- halt_req and irq_pend both high at WB → HALT, halted=1. After start → FETCH, then EXC after the next WB.
- Watchdog build, fetch_ack never asserted → HALT after 16 cycles and err_timeout=1. err_timeout stays 1 after start; only rst clears it.
- Counter wrap with CNT_W=4: 16 instructions → retired returns to 0. rst asserted mid-MEM → all outputs 0 in the same cycle.
